// File: rtl/switch_event_reader.sv
// Switch/button front end: 2-flop sync, tick-paced debounce, and a show-ahead
// FIFO of {state, rise, fall} change events behind a valid/ready handshake.
module switch_event_reader #(
  parameter int TICK_DIV     = 27000,
  parameter int STABLE_TICKS = 20,
  parameter int DEPTH        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_raw,
  output logic [3:0] sw_state,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [3:0] ev_state,
  output logic [3:0] ev_rise,
  output logic [3:0] ev_fall,
  output logic       overflow
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [3:0]       sync1_reg, sync2_reg;
  logic [DIV_W-1:0] div_cnt_reg;
  logic             tick;
  logic [3:0]       sw_state_reg;
  logic [3:0]       flip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= sw_raw;
      sync2_reg <= sync1_reg;
    end
  end

  assign tick = (div_cnt_reg == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      div_cnt_reg <= '0;
    else if (tick)
      div_cnt_reg <= '0;
    else
      div_cnt_reg <= div_cnt_reg + 1'b1;
  end

  // A bit flips on the tick that completes STABLE_TICKS consecutive mismatches.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      logic [CNT_W-1:0] cnt_reg;
      logic             mismatch;

      assign mismatch  = (sync2_reg[gi] != sw_state_reg[gi]);
      assign flip[gi]  = tick && mismatch && (cnt_reg == CNT_LAST);

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          cnt_reg <= '0;
        else if (tick) begin
          if (!mismatch || flip[gi])
            cnt_reg <= '0;
          else
            cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sw_state_reg <= '0;
    else
      sw_state_reg <= sw_state_reg ^ flip;
  end

  assign sw_state = sw_state_reg;

  logic        push, pop, do_push, empty, full;
  logic [11:0] push_data, head;
  logic [11:0] mem [DEPTH];
  logic [PTR_W:0] wr_ptr_reg, rd_ptr_reg;
  logic        overflow_reg;

  assign push      = |flip;
  assign push_data = {sw_state_reg ^ flip, flip & ~sw_state_reg, flip & sw_state_reg};

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                   (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign pop     = !empty && ev_ready;
  assign do_push = push && (!full || pop);

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && full && !pop)
        overflow_reg <= 1'b1;
    end
  end

  // Head is read combinationally so a new event is visible on its push edge.
  assign head     = mem[rd_ptr_reg[PTR_W-1:0]];
  assign ev_valid = !empty;
  assign ev_state = ev_valid ? head[11:8] : 4'b0000;
  assign ev_rise  = ev_valid ? head[7:4]  : 4'b0000;
  assign ev_fall  = ev_valid ? head[3:0]  : 4'b0000;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_switch_event_reader.sv
// Directed bench for switch_event_reader with a small debounce setting;
// accepted events are logged at the falling edge and checked against tables.
module tb_switch_event_reader;

  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;
  localparam int DEPTH        = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw_raw = 4'b0000;
  logic       ev_ready = 1'b1;
  logic [3:0] sw_state, ev_state, ev_rise, ev_fall;
  logic       ev_valid, overflow;

  switch_event_reader #(
    .TICK_DIV(TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_raw(sw_raw),
    .sw_state(sw_state),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_state(ev_state),
    .ev_rise(ev_rise),
    .ev_fall(ev_fall),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;
  int n, lb;
  logic [11:0] log_q[$];

  typedef struct {
    logic [3:0] raw;
    logic [3:0] exp_state;
    logic       exp_ovf;
  } bp_vec_t;

  bp_vec_t     bp_tbl[5];
  logic [11:0] bp_exp[4];
  logic [11:0] fc_exp[5];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!rst && ev_valid && ev_ready)
      log_q.push_back({ev_state, ev_rise, ev_fall});

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else
      $display("ok   %s: %0h", name, act);
  endtask

  task automatic check_entry(input string name, input int idx, input logic [11:0] exp);
    checks++;
    if (idx >= log_q.size()) begin
      errors++;
      $display("FAIL %s: got no event expected %03h", name, exp);
    end else if (log_q[idx] !== exp) begin
      errors++;
      $display("FAIL %s: got %03h expected %03h", name, log_q[idx], exp);
    end else
      $display("ok   %s: %03h", name, log_q[idx]);
  endtask

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [3:0] raw);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sw_raw = raw;
    cycles(3);
    rst = 1'b0;
    base = cyc;
  endtask

  task automatic measure_flip(input string name, input logic [3:0] target);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (sw_state == target) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n < 11 || n > 14) begin
      errors++;
      $display("FAIL %s: got %0d cycles expected 11..14", name, n);
    end else
      $display("ok   %s: %0d cycles", name, n);
  endtask

  initial begin
    bp_tbl[0] = '{4'b0001, 4'b0001, 1'b0};
    bp_tbl[1] = '{4'b0011, 4'b0011, 1'b0};
    bp_tbl[2] = '{4'b0111, 4'b0111, 1'b0};
    bp_tbl[3] = '{4'b1111, 4'b1111, 1'b0};
    bp_tbl[4] = '{4'b1110, 4'b1110, 1'b1};
    bp_exp[0] = {4'b0001, 4'b0001, 4'b0000};
    bp_exp[1] = {4'b0011, 4'b0010, 4'b0000};
    bp_exp[2] = {4'b0111, 4'b0100, 4'b0000};
    bp_exp[3] = {4'b1111, 4'b1000, 4'b0000};
    for (int i = 0; i < 4; i++) fc_exp[i] = bp_exp[i];
    fc_exp[4] = {4'b1110, 4'b0000, 4'b0001};

    // Power-up hold
    rst = 1'b1;
    sw_raw = 4'b0110;
    ev_ready = 1'b1;
    cycles(3);
    check("rst_sw_state", sw_state, 0);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_state", ev_state, 0);
    check("rst_ev_rise", ev_rise, 0);
    check("rst_ev_fall", ev_fall, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    base = cyc;
    lb = log_q.size();
    measure_flip("pwr_latency", 4'b0110);
    check("pwr_ev_valid", ev_valid, 1);
    check("pwr_head", {ev_state, ev_rise, ev_fall}, {4'b0110, 4'b0110, 4'b0000});
    cycles(20);
    check("pwr_event_count", log_q.size() - lb, 1);
    check_entry("pwr_event", lb, {4'b0110, 4'b0110, 4'b0000});

    // Glitch rejection
    apply_reset(4'b0000);
    cycles(20);
    lb = log_q.size();
    sw_raw = 4'b0001;
    cycles(8);
    sw_raw = 4'b0000;
    cycles(20);
    check("glitch8_sw_state", sw_state, 0);
    check("glitch8_no_event", log_q.size() - lb, 0);
    sw_raw = 4'b0001;
    cycles(12);
    sw_raw = 4'b0000;
    cycles(2);
    check("pulse12_sw_state", sw_state, 4'b0001);
    cycles(20);
    check("pulse12_back", sw_state, 0);
    check("pulse12_event_count", log_q.size() - lb, 2);
    check_entry("pulse12_rise", lb, {4'b0001, 4'b0001, 4'b0000});
    check_entry("pulse12_fall", lb + 1, {4'b0000, 4'b0000, 4'b0001});

    // Simultaneous edges
    sw_raw = 4'b0110;
    cycles(20);
    lb = log_q.size();
    sw_raw = 4'b1001;
    cycles(20);
    check("simul_sw_state", sw_state, 4'b1001);
    check("simul_event_count", log_q.size() - lb, 1);
    check_entry("simul_event", lb, {4'b1001, 4'b1001, 4'b0110});

    // Backpressure and overflow
    apply_reset(4'b0000);
    ev_ready = 1'b0;
    lb = log_q.size();
    for (int i = 0; i < 5; i++) begin
      sw_raw = bp_tbl[i].raw;
      cycles(20);
      check($sformatf("bp%0d_sw_state", i), sw_state, bp_tbl[i].exp_state);
      check($sformatf("bp%0d_ev_valid", i), ev_valid, 1);
      check($sformatf("bp%0d_head", i), {ev_state, ev_rise, ev_fall}, bp_exp[0]);
      check($sformatf("bp%0d_overflow", i), overflow, bp_tbl[i].exp_ovf);
    end
    ev_ready = 1'b1;
    cycles(10);
    check("bp_drain_count", log_q.size() - lb, 4);
    for (int i = 0; i < 4; i++)
      check_entry($sformatf("bp_drain%0d", i), lb + i, bp_exp[i]);
    check("bp_ev_valid_low", ev_valid, 0);
    check("bp_gated_rise", ev_rise, 0);
    check("bp_overflow_sticky", overflow, 1);

    // Full FIFO with a pop on the push cycle
    apply_reset(4'b0000);
    ev_ready = 1'b0;
    lb = log_q.size();
    for (int i = 0; i < 4; i++) begin
      sw_raw = bp_tbl[i].raw;
      cycles(20);
    end
    do begin
      @(posedge clk);
      #1;
    end while (((cyc - base) % TICK_DIV) != 0);
    sw_raw = 4'b1110;
    cycles(11);
    check("fc_pre_flip_state", sw_state, 4'b1111);
    ev_ready = 1'b1;
    cycles(1);
    ev_ready = 1'b0;
    check("fc_flip_state", sw_state, 4'b1110);
    check("fc_ev_valid", ev_valid, 1);
    check("fc_overflow", overflow, 0);
    check("fc_head", {ev_state, ev_rise, ev_fall}, fc_exp[1]);
    ev_ready = 1'b1;
    cycles(10);
    check("fc_drain_count", log_q.size() - lb, 5);
    for (int i = 0; i < 5; i++)
      check_entry($sformatf("fc_drain%0d", i), lb + i, fc_exp[i]);
    check("fc_overflow_end", overflow, 0);

    // Reset mid-debounce with events queued
    apply_reset(4'b0000);
    ev_ready = 1'b0;
    sw_raw = 4'b0001;
    cycles(20);
    sw_raw = 4'b0011;
    cycles(20);
    check("rmd_queued_valid", ev_valid, 1);
    sw_raw = 4'b0111;
    cycles(7);
    rst = 1'b1;
    #1;
    check("rmd_ev_valid", ev_valid, 0);
    check("rmd_sw_state", sw_state, 0);
    check("rmd_overflow", overflow, 0);
    check("rmd_ev_state", ev_state, 0);
    ev_ready = 1'b1;
    lb = log_q.size();
    cycles(2);
    rst = 1'b0;
    base = cyc;
    measure_flip("rmd_latency", 4'b0111);
    cycles(20);
    check("rmd_event_count", log_q.size() - lb, 1);
    check_entry("rmd_event", lb, {4'b0111, 4'b0111, 4'b0000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_event_reader.md
# switch_event_reader

Input-side companion to the board's LED pattern drivers. It samples the 4 raw slide switches or buttons, synchronizes and debounces them against a slow internal tick, and reports every debounced change as an event. Each event carries the new state and per-bit rise/fall masks and is queued in a small FIFO behind a valid/ready handshake. Downstream pattern logic consumes clean events instead of reading raw pins combinationally.

## Interface
Parameters:
- TICK_DIV, 27000: clk cycles per debounce sample tick (1 kHz at 27 MHz).
- STABLE_TICKS, 20: consecutive mismatching ticks needed before a bit flips; must be ≥1.
- DEPTH, 4: event FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset; clears all state.
- sw_raw  in  4  raw asynchronous switch/button levels.
- sw_state  out  4  debounced level, registered.
- ev_valid  out  1  FIFO non-empty; head event presented.
- ev_ready  in  1  consumer accepts head when ev_valid=1.
- ev_state  out  4  sw_state value after the event.
- ev_rise  out  4  bits that went 0→1 in this event.
- ev_fall  out  4  bits that went 1→0 in this event.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.

## Operation
- **Synchronizer:** 2-flop per bit, reset 0; sync[3:0] is the debouncer input.
- **Prescaler:** counter runs 0..TICK_DIV-1 and wraps. The tick is a 1-cycle pulse when the counter equals TICK_DIV-1. Counter reset value is 0.
- **Debounce, per bit, evaluated only on tick:**
  - sync==sw_state: cnt←0.
  - mismatch and cnt==STABLE_TICKS-1: sw_state←sync, cnt←0.
  - other mismatch: cnt←cnt+1.
  - Any matching tick restarts the count. Glitches shorter than STABLE_TICKS ticks never propagate.
- **Event generation:** on a tick where ≥1 bit flips, push one entry {new state, rise mask, fall mask} on the same edge that updates sw_state.
  - Bits flipping on the same tick share one event. Rise and fall may both be non-zero.
  - At most one push per TICK_DIV cycles.
- **FIFO:** show-ahead, DEPTH entries, separate read/write pointers with an extra wrap bit for full/empty.
  - Pop when ev_valid && ev_ready.
  - Push with FIFO full and no pop in the same cycle: the new event is dropped, existing entries are kept, overflow←1.
  - Push and pop in the same cycle with FIFO full: both take effect and overflow is not set.
  - Push and pop in the same cycle with FIFO empty: impossible, since pop requires ev_valid.
  - Entries are delivered in push order.
- **Output gating:** ev_state, ev_rise and ev_fall read 0 whenever ev_valid=0.
- **overflow:** cleared only by rst.
- **Reset mid-operation:** FIFO contents are discarded. Synchronizer, prescaler, debounce counters, sw_state and overflow all clear. After release, any switch held at 1 is reported as a rise event once it is debounced from sw_state=0.

## Timing
- Reset values: sw_state=0, ev_valid=0, ev_state/ev_rise/ev_fall=0, overflow=0.
- Latency from an sw_raw change (held stable) to sw_state: 2 sync cycles, then STABLE_TICKS tick edges.
  - Range is 3+(STABLE_TICKS-1)·TICK_DIV to 2+STABLE_TICKS·TICK_DIV clk cycles.
- ev_valid rises on the same edge as the sw_state change when the FIFO was empty (0 extra cycles).
- Handshake: the consumer may hold ev_ready high permanently. Throughput is 1 event/cycle when entries are queued.
- The head entry must stay stable while ev_valid=1 and ev_ready=0.
- ev_ready is ignored while ev_valid=0.

## Test plan
All scenarios use TICK_DIV=4, STABLE_TICKS=3, DEPTH=4, ev_ready=1 unless noted.
- **Power-up hold:** rst held with sw_raw=4'b0110, then released.
  - sw_state=0 until debounce completes, then sw_state=0110.
  - One event: state=0110, rise=0110, fall=0000.
  - Flip lands within 11..14 cycles of release.
- **Glitch rejection:** from a stable 0000, pulse sw_raw[0]=1 for 8 cycles (2 ticks), then back to 0.
  - sw_state remains 0000 and no event is produced.
  - Repeat with a 12-cycle pulse: flip to 0001 occurs.
- **Simultaneous edges:** stable 0110, then sw_raw=1001.
  - Exactly one event: state=1001, rise=1001, fall=0110.
- **Backpressure/overflow:** ev_ready=0, generate 5 debounced changes 0001, 0011, 0111, 1111, 1110.
  - overflow=1 after the 5th change.
  - With ev_ready=1, the drain yields the first 4 events in order; the 5th is absent.
  - ev_valid falls after 4 pops.
- **Full + concurrent pop:** with the FIFO full, assert ev_ready for exactly the cycle of a new push.
  - Occupancy stays 4, overflow stays 0, and the new event appears last on drain.
- **Reset mid-debounce:** assert rst while a flip is half counted and 2 events are queued.
  - ev_valid=0 and sw_state=0 immediately, and overflow=0.
  - After release, the current switch level is re-debounced and reported as a single fresh event.
